aes_key_unroll: RTL and testbench
=================================

Name: aes_key_unroll

Overview:
- Inverse AES-128 key schedule. Takes the final (round-10) round key and walks the expansion backwards, one round per enabled cycle.
- Emits round keys 9 down to 0. Round 0 is the original cipher key.
- Feeds the decryption datapath, which consumes round keys in reverse order.
- Counterpart of the forward key_single_round expansion; shares its word ordering and Rcon values.

Parameters:
- NUM_ROUNDS, 10, number of AES-128 rounds. Only 10 is supported; elaboration fails on any other value.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- clk_en_i  input  1  global clock enable; when low, all state and outputs hold
- start_i  input  1  request to unroll key_i; accepted only when ready_o && clk_en_i
- key_i  input  128  round-10 key; [127:96] = w40 ... [31:0] = w43
- ready_o  output  1  block idle and able to accept start_i
- key_o  output  128  current round key, same word ordering as key_i
- round_o  output  4  round index of key_o (9..0)
- key_valid_o  output  1  key_o/round_o valid
- done_o  output  1  asserted together with the round-0 key

Behaviour:
- Reset (rst_i=1 at a clk_i edge, overrides clk_en_i):
  - state=IDLE, ready_o=1, key_o=0, round_o=0, key_valid_o=0, done_o=0.
  - An in-progress unroll is abandoned with no further outputs.
- clk_en_i=0: nothing updates. Outputs hold their last values, including key_valid_o/done_o; consumers qualify with clk_en_i.
- FSM states:
  - IDLE: ready_o=1. On start_i && clk_en_i: capture key_i into the working register, set round counter r=10, go to RUN, ready_o=0. key_valid_o=0 and done_o=0 in the capture cycle.
  - RUN: each enabled cycle derives key(r-1) from key(r) (formula below), writes it to key_o and the working register, sets round_o=r-1, key_valid_o=1, then decrements r.
    - When r-1 = 0: done_o=1 and return to IDLE (ready_o=1 from the next cycle).
- Derivation of key(r-1) from key(r) = {a0,a1,a2,a3}, where a0 = bits [127:96]:
  - p3 = a3^a2
  - p2 = a2^a1
  - p1 = a1^a0
  - p0 = a0 ^ SubWord(RotWord(p3)) ^ {rcon[r],24'h0}
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Single-cycle combinational round; no pipelining.
- Latency: capture edge + 10 enabled edges. First valid key (round 9) appears 1 enabled cycle after accept; round 0 appears 10 enabled cycles after accept.
- key_valid_o is high for exactly 10 consecutive enabled cycles per request.
- After the round-0 cycle, key_valid_o and done_o drop to 0 on the next enabled edge, unless a new start_i is accepted there. In that case the same capture-cycle rule applies and they still drop to 0.
- start_i while in RUN is ignored; no queuing.
- start_i with clk_en_i=0 is ignored.
- key_i is sampled only in the accept cycle; later changes have no effect.
- round_o never wraps: the counter leaves RUN at 0.

Decomposition:
- aes_pkg holds:
  - word_t (logic [31:0])
  - NUM_ROUNDS_AES128 constant
  - RCON_LUT[1:10] constant
  - rot_word function
  - SBOX constant table; shared with the forward key schedule and the cipher rounds
- One sub-module: aes_sub_word, combinational, 32-bit in/out, four SBOX lookups. Instantiated once.

Test Plan:
- FIPS-197 A.1 key: reset 2 cycles, start_i with key_i=d014f9a8c9ee2589e13f0cc8b6630ca6.
  -> round 9 = ac7766f319fadc2128d12941575c006e
  -> round 1 = a0fafe1788542cb123a339392a6c7605
  -> round 0 = 2b7e151628aed2a6abf7158809cf4f3c with done_o=1
  -> exactly 10 valid cycles.
- Round-trip: for 50 random cipher keys, expand forward with the reference model and feed the round-10 key -> round 0 equals the original key; each intermediate key matches the forward schedule.
- Stall: same key, clk_en_i toggled pseudo-randomly -> identical key sequence; outputs frozen during every low cycle; still 10 enabled cycles to done_o.
- Busy start: pulse start_i with a different key at round 5 -> ignored; sequence completes for the first key; ready_o=0 until after done_o.
- Reset mid-run: assert rst_i at round 4 -> next cycle key_valid_o=0, done_o=0, ready_o=1, key_o=0; a fresh start then produces the full correct sequence.
- Back-to-back: start_i held high continuously with two keys -> second request accepted in the cycle after done_o; key_valid_o and done_o are 0 in that capture cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, round count, Rcon, RotWord and the S-box used
// by the key schedules and the cipher rounds.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam int NUM_ROUNDS_AES128 = 10;

  localparam logic [7:0] RCON_LUT [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // {b0,b1,b2,b3} -> {b1,b2,b3,b0}, b0 being the most significant byte
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box independently to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_o[gi*8 +: 8] = SBOX[word_i[gi*8 +: 8]];
  end

endmodule

// File: rtl/aes_key_unroll.sv
// Inverse AES-128 key schedule: from the round-10 key, emits round keys 9..0,
// one per enabled cycle, for the decryption datapath.
module aes_key_unroll
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_en_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         ready_o,
  output logic [127:0] key_o,
  output logic [3:0]   round_o,
  output logic         key_valid_o,
  output logic         done_o
);

  if (NUM_ROUNDS != NUM_ROUNDS_AES128) begin : g_bad_rounds
    $error("aes_key_unroll supports only NUM_ROUNDS = 10");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS_AES128);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t       r_state, w_state_next;
  logic [127:0] r_work, w_work_next;
  logic [3:0]   r_cnt, w_cnt_next;
  logic [127:0] r_key, w_key_next;
  logic [3:0]   r_round, w_round_next;
  logic         r_valid, w_valid_next;
  logic         r_done, w_done_next;

  word_t        w_a0, w_a1, w_a2, w_a3;
  word_t        w_p0, w_p1, w_p2, w_p3;
  word_t        w_sub;
  logic [7:0]   w_rcon;
  logic [127:0] w_prev_key;

  assign {w_a0, w_a1, w_a2, w_a3} = r_work;

  assign w_p3 = w_a3 ^ w_a2;
  assign w_p2 = w_a2 ^ w_a1;
  assign w_p1 = w_a1 ^ w_a0;

  aes_sub_word u_sub_word (
    .word_i (rot_word(w_p3)),
    .word_o (w_sub)
  );

  // r_cnt sits outside 1..10 only while idle, where the derived key is unused
  assign w_rcon     = (r_cnt >= 4'd1 && r_cnt <= LAST_ROUND) ? RCON_LUT[r_cnt] : 8'h00;
  assign w_p0       = w_a0 ^ w_sub ^ {w_rcon, 24'h0};
  assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_cnt_next   = r_cnt;
    w_key_next   = r_key;
    w_round_next = r_round;
    w_valid_next = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_work_next  = key_i;
          w_cnt_next   = LAST_ROUND;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_work_next  = w_prev_key;
        w_key_next   = w_prev_key;
        w_round_next = r_cnt - 4'd1;
        w_cnt_next   = r_cnt - 4'd1;
        w_valid_next = 1'b1;
        if (r_cnt == 4'd1) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_key   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (clk_en_i) begin
      r_state <= w_state_next;
      r_work  <= w_work_next;
      r_cnt   <= w_cnt_next;
      r_key   <= w_key_next;
      r_round <= w_round_next;
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
    end
  end

  assign ready_o     = (r_state == ST_IDLE);
  assign key_o       = r_key;
  assign round_o     = r_round;
  assign key_valid_o = r_valid;
  assign done_o      = r_done;

endmodule

// File: tb/tb_aes_key_unroll.sv
// Bench for aes_key_unroll: forward-expansion reference model with a GF(2^8)-derived S-box.
module tb_aes_key_unroll;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         clk_en_i = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         ready_o;
  logic [127:0] key_o;
  logic [3:0]   round_o;
  logic         key_valid_o;
  logic         done_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] rk  [0:10];
  logic [127:0] rka [0:10];

  always #5 clk_i = ~clk_i;

  aes_key_unroll #(.NUM_ROUNDS(10)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clk_en_i    (clk_en_i),
    .start_i     (start_i),
    .key_i       (key_i),
    .ready_o     (ready_o),
    .key_o       (key_o),
    .round_o     (round_o),
    .key_valid_o (key_valid_o),
    .done_o      (done_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Forward AES-128 key expansion into rk[0..10]
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready_o && n < 30) begin
      tick();
      n++;
    end
    if (!ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ready: ready_o=%b after %0d cycles, required 1", ready_o, n);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clk_en_i = 1'b1; start_i = 1'b0;
    tick();
    clk_en_i = 1'b0;
    tick();
    rst_i = 1'b0; clk_en_i = 1'b1;
    n_tests++;
    if ({ready_o, key_o, round_o, key_valid_o, done_o} !== {1'b1, 128'h0, 4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b key=%h rnd=%0d vld=%b done=%b, required rdy=1 key=0 rnd=0 vld=0 done=0",
               ready_o, key_o, round_o, key_valid_o, done_o);
    end
  endtask

  task automatic test_fips();
    int nvalid;
    logic [127:0] exp_const;
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    n_tests++;
    if (rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++;
      $display("FAIL fips_model: model rk10=%h required d014f9a8c9ee2589e13f0cc8b6630ca6", rk[10]);
    end
    wait_ready();
    start_i = 1'b1; key_i = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    tick();
    start_i = 1'b0; key_i = rand128();
    n_tests++;
    if ({key_valid_o, done_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL fips_capture: vld=%b done=%b, required 0 0", key_valid_o, done_o);
    end
    nvalid = 0;
    for (int j = 9; j >= 0; j--) begin
      tick();
      if (key_valid_o) nvalid++;
      n_tests++;
      if ({key_o, round_o, key_valid_o, done_o} !== {rk[j], 4'(j), 1'b1, (j == 0)}) begin
        n_fail++;
        $display("FAIL fips_round r%0d: key=%h rnd=%0d vld=%b done=%b, required key=%h vld=1 done=%b",
                 j, key_o, round_o, key_valid_o, done_o, rk[j], (j == 0));
      end
      if (j == 9 || j == 1 || j == 0) begin
        exp_const = (j == 9) ? 128'hac7766f319fadc2128d12941575c006e :
                    (j == 1) ? 128'ha0fafe1788542cb123a339392a6c7605 :
                               128'h2b7e151628aed2a6abf7158809cf4f3c;
        n_tests++;
        if (key_o !== exp_const) begin
          n_fail++;
          $display("FAIL fips_vector r%0d: key=%h, required %h", j, key_o, exp_const);
        end
      end
    end
    tick();
    if (key_valid_o) nvalid++;
    n_tests++;
    if ({key_valid_o, done_o} !== 2'b00 || nvalid != 10) begin
      n_fail++;
      $display("FAIL fips_tail: vld=%b done=%b valid_cycles=%0d, required 0 0 10", key_valid_o, done_o, nvalid);
    end
  endtask

  task automatic test_roundtrip();
    logic [127:0] ck;
    for (int k = 0; k < 50; k++) begin
      ck = rand128();
      expand(ck);
      wait_ready();
      start_i = 1'b1; key_i = rk[10];
      tick();
      start_i = 1'b0; key_i = rand128();
      for (int j = 9; j >= 0; j--) begin
        tick();
        n_tests++;
        if ({key_o, round_o, key_valid_o, done_o} !== {(j == 0) ? ck : rk[j], 4'(j), 1'b1, (j == 0)}) begin
          n_fail++;
          $display("FAIL roundtrip k%0d r%0d: key=%h rnd=%0d vld=%b done=%b, required key=%h",
                   k, j, key_o, round_o, key_valid_o, done_o, rk[j]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int en_cnt;
    bit en_now;
    logic [134:0] snap;
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    tick();
    wait_ready();
    en_cnt = 0;
    start_i = 1'b1; key_i = rk[10];
    snap = {ready_o, key_o, round_o, key_valid_o, done_o};
    for (int cyc = 0; cyc < 300 && en_cnt < 11; cyc++) begin
      en_now = (cyc % 4 == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      clk_en_i = en_now;
      tick();
      if (!en_now) begin
        n_tests++;
        if ({ready_o, key_o, round_o, key_valid_o, done_o} !== snap) begin
          n_fail++;
          $display("FAIL stall_hold cyc%0d: outputs=%h, required frozen %h", cyc,
                   {ready_o, key_o, round_o, key_valid_o, done_o}, snap);
        end
      end else begin
        en_cnt++;
        if (en_cnt == 1) begin
          start_i = 1'b0; key_i = rand128();
          n_tests++;
          if ({ready_o, key_valid_o, done_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_capture: rdy=%b vld=%b done=%b, required 0 0 0", ready_o, key_valid_o, done_o);
          end
        end else begin
          n_tests++;
          if ({key_o, round_o, key_valid_o, done_o} !== {rk[11-en_cnt], 4'(11-en_cnt), 1'b1, (en_cnt == 11)}) begin
            n_fail++;
            $display("FAIL stall_round r%0d: key=%h rnd=%0d vld=%b done=%b, required key=%h",
                     11-en_cnt, key_o, round_o, key_valid_o, done_o, rk[11-en_cnt]);
          end
        end
      end
      snap = {ready_o, key_o, round_o, key_valid_o, done_o};
    end
    clk_en_i = 1'b1; start_i = 1'b0;
    n_tests++;
    if (en_cnt < 11) begin
      n_fail++;
      $display("FAIL stall_timeout: enabled edges=%0d, required 11", en_cnt);
    end
  endtask

  task automatic test_busy_start();
    logic [127:0] kb;
    expand(rand128());
    kb = rand128();
    wait_ready();
    start_i = 1'b1; key_i = rk[10];
    tick();
    start_i = 1'b0; key_i = rand128();
    for (int j = 9; j >= 0; j--) begin
      tick();
      if (j == 4) start_i = 1'b0;
      n_tests++;
      if ({key_o, round_o, key_valid_o, done_o} !== {rk[j], 4'(j), 1'b1, (j == 0)} ||
          (j > 0 && ready_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL busy_round r%0d: key=%h rnd=%0d vld=%b done=%b rdy=%b, required key=%h",
                 j, key_o, round_o, key_valid_o, done_o, ready_o, rk[j]);
      end
      if (j == 5) begin
        start_i = 1'b1; key_i = kb;
      end
    end
    tick();
    n_tests++;
    if ({ready_o, key_valid_o, done_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL busy_after: rdy=%b vld=%b done=%b, required 1 0 0", ready_o, key_valid_o, done_o);
    end
  endtask

  task automatic test_reset_mid();
    expand(rand128());
    wait_ready();
    start_i = 1'b1; key_i = rk[10];
    tick();
    start_i = 1'b0;
    for (int j = 9; j >= 4; j--) begin
      tick();
      n_tests++;
      if ({key_o, round_o, key_valid_o} !== {rk[j], 4'(j), 1'b1}) begin
        n_fail++;
        $display("FAIL rstmid_round r%0d: key=%h rnd=%0d vld=%b, required key=%h", j, key_o, round_o, key_valid_o, rk[j]);
      end
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_tests++;
    if ({ready_o, key_o, round_o, key_valid_o, done_o} !== {1'b1, 128'h0, 4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_clear: rdy=%b key=%h rnd=%0d vld=%b done=%b, required 1 0 0 0 0",
               ready_o, key_o, round_o, key_valid_o, done_o);
    end
    tick();
    n_tests++;
    if ({ready_o, key_valid_o, done_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_abandon: rdy=%b vld=%b done=%b, required 1 0 0", ready_o, key_valid_o, done_o);
    end
    expand(rand128());
    start_i = 1'b1; key_i = rk[10];
    tick();
    start_i = 1'b0;
    for (int j = 9; j >= 0; j--) begin
      tick();
      n_tests++;
      if ({key_o, round_o, key_valid_o, done_o} !== {rk[j], 4'(j), 1'b1, (j == 0)}) begin
        n_fail++;
        $display("FAIL rstmid_fresh r%0d: key=%h rnd=%0d vld=%b done=%b, required key=%h",
                 j, key_o, round_o, key_valid_o, done_o, rk[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] kb10;
    expand(rand128());
    for (int r = 0; r <= 10; r++) rka[r] = rk[r];
    expand(rand128());
    kb10 = rk[10];
    tick();
    wait_ready();
    start_i = 1'b1; key_i = rka[10];
    tick();
    key_i = kb10;
    for (int j = 9; j >= 0; j--) begin
      tick();
      n_tests++;
      if ({key_o, round_o, key_valid_o, done_o} !== {rka[j], 4'(j), 1'b1, (j == 0)}) begin
        n_fail++;
        $display("FAIL b2b_first r%0d: key=%h rnd=%0d vld=%b done=%b, required key=%h",
                 j, key_o, round_o, key_valid_o, done_o, rka[j]);
      end
    end
    tick();
    start_i = 1'b0; key_i = rand128();
    n_tests++;
    if ({ready_o, key_valid_o, done_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_capture: rdy=%b vld=%b done=%b, required 0 0 0", ready_o, key_valid_o, done_o);
    end
    for (int j = 9; j >= 0; j--) begin
      tick();
      n_tests++;
      if ({key_o, round_o, key_valid_o, done_o} !== {rk[j], 4'(j), 1'b1, (j == 0)}) begin
        n_fail++;
        $display("FAIL b2b_second r%0d: key=%h rnd=%0d vld=%b done=%b, required key=%h",
                 j, key_o, round_o, key_valid_o, done_o, rk[j]);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_roundtrip();
    test_stall();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
